reg_native_if_arb: RTL and testbench

Round-robin arbiter that shares one native register-access port among `N_REQ` requesters, such as a debug master, a firmware mailbox and a DMA descriptor loader. It sits directly upstream of the native-to-APB bridge. It serialises requests to one outstanding transaction, issues each as a single-cycle `m_req_vld` pulse, and routes completion and read data back to the granted requester. Malformed commands are rejected locally with an error and never issued downstream.

---
 rtl/reg_native_if_arb.sv | 157 +++++++++++++++
 tb/tb_reg_native_if_arb.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_native_if_arb.sv
// reg_native_if_arb
//   Round-robin arbiter that shares one native register-access port among
//   N_REQ requesters. Only one transaction is outstanding at a time. Each
//   granted command is issued downstream as a single-cycle m_req_vld pulse,
//   and the completion is routed back to the granted requester. A command
//   with both or neither of wr_en/rd_en set is rejected locally with s_err
//   and is never issued downstream.
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   s_req_vld        per-requester request, held until that requester's ack
//   s_wr_en/s_rd_en  per-requester command
//   s_addr           flattened, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   s_wr_data        flattened, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_ack_vld        one-hot completion pulse, one cycle
//   s_err            qualifies s_ack_vld: 1 = rejected command
//   s_rd_data        shared read data, valid with s_ack_vld
//   m_req_vld        downstream request pulse
//   m_wr_en/m_rd_en  downstream command, held from grant to next grant
//   m_addr/m_wr_data downstream address and write data
//   m_ack_vld        raw downstream completion, honoured only in WAIT
//   m_rd_data        downstream read data
//   gnt_id           index of the current or last grant
//   busy             high whenever the FSM is not idle
module reg_native_if_arb #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  localparam int ID_WIDTH  = $clog2(N_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            s_req_vld,
  input  logic [N_REQ-1:0]            s_wr_en,
  input  logic [N_REQ-1:0]            s_rd_en,
  input  logic [N_REQ*ADDR_WIDTH-1:0] s_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_wr_data,
  output logic [N_REQ-1:0]            s_ack_vld,
  output logic                        s_err,
  output logic [DATA_WIDTH-1:0]       s_rd_data,
  output logic                        m_req_vld,
  output logic                        m_wr_en,
  output logic                        m_rd_en,
  output logic [ADDR_WIDTH-1:0]       m_addr,
  output logic [DATA_WIDTH-1:0]       m_wr_data,
  input  logic                        m_ack_vld,
  input  logic [DATA_WIDTH-1:0]       m_rd_data,
  output logic [ID_WIDTH-1:0]         gnt_id,
  output logic                        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_HOLD,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ID_WIDTH-1:0] rr_ptr;

  logic                found;
  logic [ID_WIDTH-1:0] winner;
  logic                sel_wr;
  logic                sel_rd;
  logic                legal;
  logic                grant;
  logic                wait_done;

  // Round-robin search: first active request at or above rr_ptr, wrapping.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && s_req_vld[(int'(rr_ptr) + i) % N_REQ]) begin
        found  = 1'b1;
        winner = ID_WIDTH'((int'(rr_ptr) + i) % N_REQ);
      end
    end
    sel_wr = s_wr_en[winner];
    sel_rd = s_rd_en[winner];
    legal  = sel_wr ^ sel_rd;
  end

  assign grant     = (state == S_IDLE) && found;
  assign wait_done = (state == S_WAIT) && m_ack_vld;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // HOLD never looks at m_ack_vld: the downstream ack may sit high outside
  // its access phase, so only WAIT may complete a transaction.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (found) state_nxt = legal ? S_ISSUE : S_RESP;
      S_ISSUE: state_nxt = S_HOLD;
      S_HOLD:  state_nxt = S_WAIT;
      S_WAIT:  if (m_ack_vld) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant bookkeeping, command latch and response capture.
  // NOTE: the datapath registers are reset too, because their reset values are visible outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      gnt_id    <= '0;
      m_wr_en   <= 1'b0;
      m_rd_en   <= 1'b0;
      m_addr    <= '0;
      m_wr_data <= '0;
      s_err     <= 1'b0;
      s_rd_data <= '0;
    end else begin
      if (grant) begin
        gnt_id    <= winner;
        rr_ptr    <= (winner == ID_WIDTH'(N_REQ - 1)) ? '0 : winner + ID_WIDTH'(1);
        m_wr_en   <= sel_wr;
        m_rd_en   <= sel_rd;
        m_addr    <= s_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        m_wr_data <= s_wr_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        if (!legal) begin
          s_err     <= 1'b1;
          s_rd_data <= '0;
        end
      end
      if (wait_done) begin
        s_rd_data <= m_rd_data;
        s_err     <= 1'b0;
      end
    end
  end

  // State-decoded outputs: no combinational path from any input.
  assign m_req_vld = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);

  always_comb begin
    s_ack_vld = '0;
    if (state == S_RESP) begin
      s_ack_vld[gnt_id] = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_native_if_arb.sv
// tb_reg_native_if_arb
//   Directed bench for reg_native_if_arb (N_REQ=4, 64-bit address, 32-bit
//   data). A behavioural downstream slave and per-requester models run
//   inside tick(); expected completions go into a scoreboard queue when a
//   request is driven and are popped when the arbiter acks.
module tb_reg_native_if_arb;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    s_req_vld;
  logic [N-1:0]    s_wr_en;
  logic [N-1:0]    s_rd_en;
  logic [N*AW-1:0] s_addr;
  logic [N*DW-1:0] s_wr_data;
  logic [N-1:0]    s_ack_vld;
  logic            s_err;
  logic [DW-1:0]   s_rd_data;
  logic            m_req_vld;
  logic            m_wr_en;
  logic            m_rd_en;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wr_data;
  logic            m_ack_vld;
  logic [DW-1:0]   m_rd_data;
  logic [1:0]      gnt_id;
  logic            busy;

  reg_native_if_arb #(
    .N_REQ     (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_req_vld(s_req_vld),
    .s_wr_en  (s_wr_en),
    .s_rd_en  (s_rd_en),
    .s_addr   (s_addr),
    .s_wr_data(s_wr_data),
    .s_ack_vld(s_ack_vld),
    .s_err    (s_err),
    .s_rd_data(s_rd_data),
    .m_req_vld(m_req_vld),
    .m_wr_en  (m_wr_en),
    .m_rd_en  (m_rd_en),
    .m_addr   (m_addr),
    .m_wr_data(m_wr_data),
    .m_ack_vld(m_ack_vld),
    .m_rd_data(m_rd_data),
    .gnt_id   (gnt_id),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    bit            err;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ack_cnt = 0;
  int last_ack_cyc = -1;
  bit spacing_on = 1'b0;

  // downstream slave model
  int            slv_cnt = 0;
  int            slv_wait = 0;
  bit            slv_tie = 1'b0;
  bit            slv_fixed = 1'b1;
  logic [DW-1:0] slv_data = '0;

  // requester models
  int            n_txn[N];
  int            txn_idx[N];
  bit            next_pend[N];
  logic [AW-1:0] req_base[N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int id, input bit err, input logic [DW-1:0] data);
    exp_t e;
    e.id   = id;
    e.err  = err;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic set_req(input int id, input bit wr, input bit rd,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int ntxn);
    s_wr_en[id]              = wr;
    s_rd_en[id]              = rd;
    s_addr[id*AW +: AW]      = addr;
    s_wr_data[id*DW +: DW]   = wdata;
    req_base[id]             = addr;
    n_txn[id]                = ntxn;
    txn_idx[id]              = 0;
    next_pend[id]            = 1'b0;
    s_req_vld[id]            = 1'b1;
  endtask

  // One clock: outputs are observed and inputs driven 1 time unit after the edge.
  task automatic tick();
    exp_t          e;
    logic [N-1:0]  one_hot;
    @(posedge clk);
    #1;
    cyc++;
    // A requester acked last cycle either moves to its next command or drops.
    for (int i = 0; i < N; i++) begin
      if (next_pend[i]) begin
        next_pend[i] = 1'b0;
        txn_idx[i]++;
        if (txn_idx[i] < n_txn[i]) s_addr[i*AW +: AW] = req_base[i] + AW'(txn_idx[i] * 4);
        else                       s_req_vld[i] = 1'b0;
      end
    end
    if (s_ack_vld !== '0) begin
      if (spacing_on && last_ack_cyc >= 0) check("ack_spacing", cyc - last_ack_cyc, 5);
      last_ack_cyc = cyc;
      ack_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_ack", s_ack_vld, 0);
      end else begin
        e = sb.pop_front();
        one_hot = '0;
        one_hot[e.id] = 1'b1;
        check("ack_onehot", s_ack_vld, one_hot);
        check("ack_err", s_err, e.err);
        check("ack_rd_data", s_rd_data, e.data);
        next_pend[e.id] = 1'b1;
      end
    end
    // slave: ack 2+slv_wait cycles after seeing the request pulse
    m_ack_vld = slv_tie;
    m_rd_data = $urandom;
    if (slv_cnt > 0) begin
      slv_cnt--;
      if (slv_cnt == 0) m_ack_vld = 1'b1;
    end
    if (m_ack_vld) m_rd_data = slv_fixed ? slv_data : (m_addr[31:0] ^ 32'hC0DE_0000);
    if (m_req_vld) slv_cnt = 2 + slv_wait;
  endtask

  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (ack_cnt < target) check("ack_timeout", ack_cnt, target);
  endtask

  task automatic clear_inputs();
    s_req_vld = '0;
    s_wr_en   = '0;
    s_rd_en   = '0;
    s_addr    = '0;
    s_wr_data = '0;
    m_ack_vld = 1'b0;
    m_rd_data = '0;
    slv_cnt   = 0;
    slv_tie   = 1'b0;
    for (int i = 0; i < N; i++) next_pend[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int c0;
    int base_cnt;
    logic [AW-1:0] a;

    // ---------------- reset values ----------------
    rst_n = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {m_req_vld, m_wr_en, m_rd_en, s_err, busy}, 0);
    check("rst_ack", s_ack_vld, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wr_data", m_wr_data, 0);
    check("rst_s_rd_data", s_rd_data, 0);
    check("rst_gnt_id", gnt_id, 0);
    rst_n = 1'b1;

    // ---------------- single read, zero-wait slave ----------------
    slv_fixed = 1'b1;
    slv_wait  = 0;
    slv_data  = 32'hA5A5_0001;
    set_req(0, 1'b0, 1'b1, 64'h100, 32'h0, 1);
    push_exp(0, 1'b0, 32'hA5A5_0001);
    c0 = cyc;
    tick();
    check("rd_req_pulse_c1", m_req_vld, 1);
    check("rd_m_addr", m_addr, 64'h100);
    check("rd_cmd", {m_wr_en, m_rd_en}, 2'b01);
    check("rd_gnt_id", gnt_id, 0);
    check("rd_busy", busy, 1);
    tick();
    check("rd_req_pulse_c2", m_req_vld, 0);
    wait_acks(1, 20);
    check("rd_latency", last_ack_cyc - c0, 4);
    repeat (2) tick();
    check("rd_idle_busy", busy, 0);

    // ---------------- all-request round-robin ----------------
    do_reset();
    slv_fixed = 1'b0;
    for (int i = 0; i < N; i++)
      set_req(i, i[0], !i[0], AW'(i * 'h1000), DW'(32'h1111_0000 + i), 8);
    for (int k = 0; k < 8 * N; k++) begin
      a = AW'((k % N) * 'h1000 + (k / N) * 4);
      push_exp(k % N, 1'b0, a[31:0] ^ 32'hC0DE_0000);
    end
    spacing_on   = 1'b1;
    last_ack_cyc = -1;
    base_cnt     = ack_cnt;
    wait_acks(base_cnt + 8 * N, 400);
    spacing_on = 1'b0;
    repeat (2) tick();
    check("rr_all_dropped", s_req_vld, 0);

    // ---------------- wait states on a write ----------------
    slv_fixed = 1'b1;
    slv_wait  = 3;
    slv_data  = 32'h1234_5678;
    set_req(1, 1'b1, 1'b0, 64'h20, 32'hDEAD_BEEF, 1);
    push_exp(1, 1'b0, 32'h1234_5678);
    base_cnt = ack_cnt;
    c0 = cyc;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("ws_req_pulse", m_req_vld, (k == 1));
      check("ws_wr_data", m_wr_data, 32'hDEAD_BEEF);
    end
    check("ws_ack_seen", ack_cnt, base_cnt + 1);
    check("ws_latency", last_ack_cyc - c0, 7);
    slv_wait = 0;
    repeat (2) tick();

    // ---------------- illegal command, then legal from another requester ----------------
    set_req(2, 1'b1, 1'b1, 64'h300, 32'h55, 1);
    push_exp(2, 1'b1, 32'h0);
    c0 = cyc;
    tick();
    check("ill_latency", last_ack_cyc - c0, 1);
    check("ill_no_issue_c1", m_req_vld, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("ill_no_issue", m_req_vld, 0);
    end
    slv_data = 32'h0BAD_F00D;
    set_req(1, 1'b0, 1'b1, 64'h140, 32'h0, 1);
    push_exp(1, 1'b0, 32'h0BAD_F00D);
    base_cnt = ack_cnt;
    wait_acks(base_cnt + 1, 20);
    repeat (2) tick();

    // ---------------- spurious ack: m_ack_vld tied high ----------------
    slv_tie   = 1'b1;
    m_ack_vld = 1'b1;
    slv_data  = 32'h5150_0005;
    set_req(3, 1'b0, 1'b1, 64'h3F0, 32'h0, 1);
    push_exp(3, 1'b0, 32'h5150_0005);
    base_cnt = ack_cnt;
    c0 = cyc;
    wait_acks(base_cnt + 1, 20);
    check("tie_latency", last_ack_cyc - c0, 4);
    slv_tie = 1'b0;
    repeat (2) tick();

    // ---------------- reset mid-transaction ----------------
    slv_wait = 10;
    set_req(2, 1'b0, 1'b1, 64'hABC0, 32'h0, 1);
    repeat (3) tick();
    check("mid_busy", busy, 1);
    check("mid_gnt_id", gnt_id, 2);
    set_req(3, 1'b1, 1'b0, 64'hDEF0, 32'h77, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", {m_req_vld, m_wr_en, m_rd_en, s_err, busy}, 0);
    check("mid_rst_ack", s_ack_vld, 0);
    check("mid_rst_m_addr", m_addr, 0);
    check("mid_rst_s_rd_data", s_rd_data, 0);
    check("mid_rst_gnt_id", gnt_id, 0);
    slv_cnt   = 0;
    m_ack_vld = 1'b0;
    repeat (2) tick();
    rst_n    = 1'b1;
    slv_wait = 0;
    slv_data = 32'h7777_0002;
    push_exp(2, 1'b0, 32'h7777_0002);
    push_exp(3, 1'b0, 32'h7777_0002);
    base_cnt = ack_cnt;
    wait_acks(base_cnt + 2, 40);
    repeat (2) tick();

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
